urt_rx: RTL and testbench

Serial receiver for the team's 12-bit UART frame: start bit, 8 data bits, even parity bit (`^data`), two stop bits. It samples a single-bit serial line, rebuilds the frame, checks parity and stop bits, and presents the frame for one cycle with error flags. It is the receive counterpart of the `urt` frame builder and consumes the bit stream produced by shifting that 12-bit frame out MSB first.

---
 rtl/urt_pkg.sv | 20 ++
 rtl/urt_sync2.sv | 21 ++
 rtl/urt_rx.sv | 107 ++++++++++
 tb/tb_urt_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urt_pkg.sv
// Shared constants and FSM state type for the urt 12-bit UART frame (transmit and receive sides).
package urt_pkg;

    localparam int unsigned FRAME_W   = 12;
    localparam int unsigned START_BIT = 11;
    localparam int unsigned DATA_MSB  = 10;
    localparam int unsigned DATA_LSB  = 3;
    localparam int unsigned PAR_BIT   = 2;
    localparam int unsigned STOP_MSB  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } urt_state_e;

endpackage

// File: rtl/urt_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
module urt_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/urt_rx.sv
// Receiver for the 12-bit urt frame: start, 8 data (MSB first), even parity, two stop bits.
module urt_rx
    import urt_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    output logic [FRAME_W-1:0] frame_o,
    output logic [7:0]         data_o,
    output logic               valid_o,
    output logic               parity_err_o,
    output logic               stop_err_o,
    output logic               busy_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    logic               rx_s;
    urt_state_e         state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;

    urt_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_s)
    );

    // Every sample, start bit included, shifts into shreg so it holds the whole frame at DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            frame_o      <= '0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            stop_err_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_s) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                        busy_o   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt == CNT_W'(HALF - 1)) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            shreg   <= {shreg[FRAME_W-2:0], rx_s};
                        end else begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        baud_cnt <= '0;
                        shreg    <= {shreg[FRAME_W-2:0], rx_s};
                        if (state == ST_STOP && bit_cnt == 4'd10) begin
                            state <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == ST_DATA && bit_cnt == 4'd7) begin
                                state <= ST_PARITY;
                            end else if (state == ST_PARITY) begin
                                state <= ST_STOP;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_o      <= shreg;
                    data_o       <= shreg[DATA_MSB:DATA_LSB];
                    parity_err_o <= shreg[PAR_BIT] != (^shreg[DATA_MSB:DATA_LSB]);
                    stop_err_o   <= |shreg[STOP_MSB:0];
                    valid_o      <= 1'b1;
                    state        <= ST_IDLE;
                    busy_o       <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_urt_rx.sv
// Self-checking bench for urt_rx: scoreboard of expected frames popped on each valid_o pulse.
module tb_urt_rx;

    localparam int unsigned CPB = 16;

    typedef struct packed {
        logic [11:0] f;
        logic        pe;
        logic        se;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rx_in;
    logic [11:0] frame_o;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        parity_err_o;
    logic        stop_err_o;
    logic        busy_o;

    exp_t        q[$];
    int          npass;
    int          ntotal;
    int          npulse;
    int          cyc;
    int          last_valid_cyc;
    logic [11:0] last_f;

    urt_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .frame_o      (frame_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .parity_err_o (parity_err_o),
        .stop_err_o   (stop_err_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] build(input logic [7:0] d);
        return {1'b1, d, ^d, 2'b00};
    endfunction

    task automatic expect_frame(input logic [11:0] f);
        exp_t e;
        logic [7:0] d;
        d    = f[10:3];
        e.f  = f;
        e.pe = f[2] ^ (^d);
        e.se = |f[1:0];
        q.push_back(e);
        last_f = f;
    endtask

    // Drives one frame MSB first; caller must be at a negedge.
    task automatic send_frame(input logic [11:0] f);
        for (int i = 11; i >= 0; i--) begin
            rx_in = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                npulse++;
                last_valid_cyc = cyc;
                ntotal++;
                if (prev_valid) $display("FAIL valid_consecutive: valid_o high two cycles in a row at cycle %0d", cyc);
                else npass++;
                ntotal++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_valid: got frame %h, scoreboard empty", frame_o);
                end else begin
                    npass++;
                    e = q.pop_front();
                    ntotal++;
                    if (frame_o !== e.f || data_o !== e.f[10:3] || parity_err_o !== e.pe || stop_err_o !== e.se)
                        $display("FAIL sb_frame: got frame=%h data=%h pe=%b se=%b, want frame=%h data=%h pe=%b se=%b",
                                 frame_o, data_o, parity_err_o, stop_err_o, e.f, e.f[10:3], e.pe, e.se);
                    else npass++;
                end
            end
            prev_valid = valid_o;
        end
    endtask

    task automatic idle_wait(input int n);
        rx_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        ntotal++;
        if ({frame_o, data_o, valid_o, parity_err_o, stop_err_o, busy_o} !== 24'h0)
            $display("FAIL reset_outputs: got frame=%h data=%h v=%b pe=%b se=%b busy=%b, want all 0",
                     frame_o, data_o, valid_o, parity_err_o, stop_err_o, busy_o);
        else npass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        ntotal++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0)
            $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy_o, valid_o);
        else npass++;
    endtask

    task automatic test_clean_a5();
        int n0, p0;
        n0 = cyc;
        p0 = npulse;
        expect_frame(build(8'hA5));
        send_frame(build(8'hA5));
        idle_wait(20);
        ntotal++;
        if (npulse !== p0 + 1) $display("FAIL a5_pulses: got %0d, want %0d", npulse - p0, 1);
        else npass++;
        ntotal++;
        if (last_valid_cyc !== n0 + 188)
            $display("FAIL a5_latency: valid at cycle %0d, want %0d", last_valid_cyc - n0 - 1, 187);
        else npass++;
        ntotal++;
        if (frame_o !== 12'hD28 || data_o !== 8'hA5 || parity_err_o !== 1'b0 || stop_err_o !== 1'b0)
            $display("FAIL a5_outputs: got frame=%h data=%h pe=%b se=%b, want D28 A5 0 0",
                     frame_o, data_o, parity_err_o, stop_err_o);
        else npass++;
    endtask

    task automatic test_odd_parity();
        int p0;
        p0 = npulse;
        expect_frame(12'h80C);
        send_frame(12'h80C);
        idle_wait(20);
        ntotal++;
        if (frame_o !== 12'h80C || parity_err_o !== 1'b0)
            $display("FAIL par_ok: got frame=%h pe=%b, want 80C 0", frame_o, parity_err_o);
        else npass++;
        expect_frame(12'h808);
        send_frame(12'h808);
        idle_wait(20);
        ntotal++;
        if (frame_o !== 12'h808 || parity_err_o !== 1'b1)
            $display("FAIL par_bad: got frame=%h pe=%b, want 808 1", frame_o, parity_err_o);
        else npass++;
        ntotal++;
        if (npulse !== p0 + 2) $display("FAIL par_pulses: got %0d, want %0d", npulse - p0, 2);
        else npass++;
    endtask

    task automatic test_stop_err();
        int p0;
        logic [11:0] f;
        p0 = npulse;
        f  = {1'b1, 8'h5A, 1'b0, 2'b01};
        expect_frame(f);
        send_frame(f);
        ntotal++;
        if (busy_o !== 1'b1) $display("FAIL stop_restart: busy=%b after frame with high line, want 1", busy_o);
        else npass++;
        idle_wait(20);
        ntotal++;
        if (stop_err_o !== 1'b1 || frame_o !== 12'hAD1)
            $display("FAIL stop_err: got se=%b frame=%h, want 1 AD1", stop_err_o, frame_o);
        else npass++;
        ntotal++;
        if (busy_o !== 1'b0 || npulse !== p0 + 1)
            $display("FAIL stop_after: got busy=%b pulses=%0d, want 0 1", busy_o, npulse - p0);
        else npass++;
    endtask

    task automatic test_false_start();
        int p0;
        p0 = npulse;
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rx_in = 1'b0;
        ntotal++;
        if (busy_o !== 1'b1) $display("FAIL fs_busy_rise: busy=%b, want 1", busy_o);
        else npass++;
        repeat (30) @(negedge clk);
        ntotal++;
        if (busy_o !== 1'b0 || npulse !== p0)
            $display("FAIL fs_no_frame: got busy=%b pulses=%0d, want 0 0", busy_o, npulse - p0);
        else npass++;
        ntotal++;
        if (frame_o !== last_f || stop_err_o !== 1'b1)
            $display("FAIL fs_hold: got frame=%h se=%b, want %h 1", frame_o, stop_err_o, last_f);
        else npass++;
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        logic [11:0] f;
        f = build(8'hFF);
        for (int i = 11; i >= 7; i--) begin
            rx_in = f[i];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        ntotal++;
        if ({frame_o, data_o, valid_o, parity_err_o, stop_err_o, busy_o} !== 24'h0)
            $display("FAIL rst_mid: got frame=%h data=%h v=%b pe=%b se=%b busy=%b, want all 0",
                     frame_o, data_o, valid_o, parity_err_o, stop_err_o, busy_o);
        else npass++;
        @(negedge clk);
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        p0 = npulse;
        expect_frame(build(8'h3C));
        send_frame(build(8'h3C));
        idle_wait(20);
        ntotal++;
        if (frame_o !== 12'h9E0 || parity_err_o !== 1'b0 || npulse !== p0 + 1)
            $display("FAIL rst_recover: got frame=%h pe=%b pulses=%0d, want 9E0 0 1",
                     frame_o, parity_err_o, npulse - p0);
        else npass++;
    endtask

    task automatic test_back_to_back();
        int p0;
        logic [7:0] d;
        p0 = npulse;
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom_range(255));
            expect_frame(build(d));
            send_frame(build(d));
        end
        idle_wait(40);
        ntotal++;
        if (npulse !== p0 + 20) $display("FAIL b2b_pulses: got %0d, want %0d", npulse - p0, 20);
        else npass++;
        ntotal++;
        if (q.size() != 0) $display("FAIL b2b_drain: %0d frames outstanding, want 0", q.size());
        else npass++;
        ntotal++;
        if (parity_err_o !== 1'b0 || stop_err_o !== 1'b0 || frame_o !== last_f)
            $display("FAIL b2b_last: got frame=%h pe=%b se=%b, want %h 0 0",
                     frame_o, parity_err_o, stop_err_o, last_f);
        else npass++;
    endtask

    initial begin
        npass          = 0;
        ntotal         = 0;
        npulse         = 0;
        last_valid_cyc = 0;
        last_f         = '0;
        rst_n          = 1'b0;
        rx_in          = 1'b0;
        fork
            monitor();
        join_none
        @(negedge clk);
        test_reset();
        test_clean_a5();
        test_odd_parity();
        test_stop_err();
        test_false_start();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
